// File: rtl/score_ctrl.sv
// score_ctrl: game FSM with saturating BCD score, hit combo and game-over blink for disp_num.
// Optional LEAD_ZERO_BLANK_EN blanks leading zero digits in PLAY and the OVER on-phase.
module score_ctrl #(
  parameter int PTS_PERFECT = 3,
  parameter int PTS_GOOD    = 1,
  parameter int COMBO_TH    = 10,
  parameter int BLINK_DIV   = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_start,
  input  logic        game_over,
  input  logic        hit_perfect,
  input  logic        hit_good,
  input  logic        miss,
  output logic [15:0] disp_num,
  output logic [3:0]  disp_le,
  output logic [3:0]  disp_point,
  output logic [6:0]  combo
);
  localparam int CW = $clog2(BLINK_DIV);
  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;
  state_t         r_state, w_next_state;
  logic [15:0]    r_score;
  logic [6:0]     r_combo;
  logic [CW-1:0]  r_cnt;
  logic           r_phase;
  logic           w_hit, w_bonus, w_event, w_carry;
  logic [4:0]     w_inc_bin;
  logic [7:0]     w_inc_bcd;
  logic [15:0]    w_sum;
  logic [3:0]     w_lz;
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [4:0]  s;
    logic        c;
    logic [15:0] r;
    c = 1'b0;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      s = {1'b0, a[4*k+:4]} + {1'b0, b[4*k+:4]} + {4'b0, c};
      c = s > 5'd9;
      r[4*k+:4] = c ? 4'(s - 5'd10) : s[3:0];
    end
    return {c, r};
  endfunction
  assign w_hit     = hit_perfect | hit_good;
  assign w_event   = r_state == PLAY && !game_over && (w_hit | miss);
  assign w_bonus   = 32'(r_combo) >= COMBO_TH;
  assign w_inc_bin = (hit_perfect ? 5'(PTS_PERFECT) : 5'(PTS_GOOD)) << w_bonus;
  assign w_inc_bcd = w_inc_bin > 5'd9 ? {4'd1, 4'(w_inc_bin - 5'd10)} : {4'd0, w_inc_bin[3:0]};
  assign {w_carry, w_sum} = bcd_add(r_score, {8'h00, w_inc_bcd});
  always_comb begin
    w_next_state = r_state;
    if (game_start) w_next_state = PLAY;
    else if (game_over && r_state == PLAY) w_next_state = OVER;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_score <= '0;
      r_combo <= '0;
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else begin
      r_state <= w_next_state;
      if (game_start) begin
        r_score <= '0;
        r_combo <= '0;
        r_cnt   <= '0;
        r_phase <= 1'b1;
      end else if (w_event) begin
        if (w_hit) begin
          r_score <= w_carry ? 16'h9999 : w_sum;
          r_combo <= r_combo == 7'd99 ? 7'd99 : r_combo + 7'd1;
        end else r_combo <= '0;
      end else if (r_state == OVER) begin
        r_cnt <= r_cnt == CW'(BLINK_DIV - 1) ? '0 : r_cnt + 1'b1;
        if (r_cnt == CW'(BLINK_DIV - 1)) r_phase <= ~r_phase;
      end
    end
  end
  // ones digit is never blanked; each higher digit blanks only if all above it are zero
  assign w_lz[3] = r_score[15:12] == 4'd0;
  assign w_lz[2] = w_lz[3] && r_score[11:8] == 4'd0;
  assign w_lz[1] = w_lz[2] && r_score[7:4] == 4'd0;
  assign w_lz[0] = 1'b0;
  assign disp_num   = r_score;
  assign combo      = r_combo;
  assign disp_point = {r_state == OVER, 2'b00, r_state == PLAY && w_bonus};
`ifdef LEAD_ZERO_BLANK_EN
  assign disp_le = (r_state == OVER && !r_phase) ? 4'b1111 : (r_state != IDLE ? w_lz : 4'b0000);
`else
  assign disp_le = (r_state == OVER && !r_phase) ? 4'b1111 : 4'b0000;
`endif
endmodule

// File: tb/tb_score_ctrl.sv
// tb_score_ctrl: directed + randomized checks of score_ctrl against a decimal-arithmetic game model.
module tb_score_ctrl;
  localparam int BD = 4;
  logic clk = 1'b0, rst = 1'b0, game_start = 1'b0, game_over = 1'b0;
  logic hit_perfect = 1'b0, hit_good = 1'b0, miss = 1'b0;
  logic [15:0] disp_num;
  logic [3:0]  disp_le, disp_point;
  logic [6:0]  combo;
  int checks = 0, errors = 0;
  int m_st, m_sc, m_cb, m_oc;
  score_ctrl #(.BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .game_start(game_start), .game_over(game_over),
    .hit_perfect(hit_perfect), .hit_good(hit_good), .miss(miss),
    .disp_num(disp_num), .disp_le(disp_le), .disp_point(disp_point), .combo(combo)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  function automatic logic [3:0] exp_le();
    if (m_st == 2 && (m_oc / BD) % 2 == 1) return 4'b1111;
`ifdef LEAD_ZERO_BLANK_EN
    if (m_st != 0) return m_sc < 10 ? 4'b1110 : m_sc < 100 ? 4'b1100 : m_sc < 1000 ? 4'b1000 : 4'b0000;
`endif
    return 4'b0000;
  endfunction
  task automatic check_all(input string tag);
    chk({tag, ".num"}, disp_num, to_bcd(m_sc));
    chk({tag, ".le"}, {12'h0, disp_le}, {12'h0, exp_le()});
    chk({tag, ".pt"}, {12'h0, disp_point}, {12'h0, m_st == 2, 2'b00, m_st == 1 && m_cb >= 10});
    chk({tag, ".combo"}, {9'h0, combo}, 16'(m_cb));
  endtask
  task automatic step(input string tag, input bit s, input bit o, input bit p, input bit g, input bit m);
    int inc;
    game_start = s; game_over = o; hit_perfect = p; hit_good = g; miss = m;
    @(posedge clk);
    if (s) begin m_st = 1; m_sc = 0; m_cb = 0; m_oc = 0; end
    else if (m_st == 1 && o) begin m_st = 2; m_oc = 0; end
    else if (m_st == 1 && (p || g)) begin
      inc = p ? 3 : 1;
      if (m_cb >= 10) inc *= 2;
      m_sc = m_sc + inc > 9999 ? 9999 : m_sc + inc;
      m_cb = m_cb < 99 ? m_cb + 1 : 99;
    end else if (m_st == 1 && m) m_cb = 0;
    else if (m_st == 2) m_oc++;
    #1;
    {game_start, game_over, hit_perfect, hit_good, miss} = '0;
    check_all(tag);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    m_st = 0; m_sc = 0; m_cb = 0; m_oc = 0;
    check_all("reset");
  endtask
  initial begin
    @(posedge clk); #1;
    do_reset(2);
    step("idle_hit", 0, 0, 1, 0, 0);
    chk("idle_hold", disp_num, 16'h0000);
    step("start", 1, 0, 0, 0, 0);
    step("p1", 0, 0, 1, 0, 0); chk("p1_abs", disp_num, 16'h0003);
    step("p2", 0, 0, 1, 0, 0); chk("p2_abs", disp_num, 16'h0006);
    step("p3", 0, 0, 1, 0, 0); chk("p3_abs", disp_num, 16'h0009);
    step("p4", 0, 0, 1, 0, 0); chk("p4_carry", disp_num, 16'h0012);
    step("restart", 1, 0, 0, 0, 0);
    repeat (10) step("good", 0, 0, 0, 1, 0);
    chk("good10", disp_num, 16'h0010); chk("bonus_pt", {12'h0, disp_point}, 16'h0001);
    step("good11", 0, 0, 0, 1, 0); chk("doubled", disp_num, 16'h0012);
    step("miss", 0, 0, 0, 0, 1); chk("miss_combo", {9'h0, combo}, 16'h0000);
    step("good12", 0, 0, 0, 1, 0); chk("after_miss", disp_num, 16'h0013);
    for (int i = 0; i < 300; i++)
      step("rnd_ev", 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
    for (int i = 0; i < 4000 && m_sc < 9990; i++) step("climb", 0, 0, 1, 0, 0);
    step("drop_combo", 0, 0, 0, 0, 1);
    for (int i = 0; i < 20 && m_sc < 9998; i++) step("fine", 0, 0, 0, 1, 0);
    chk("at_9998", disp_num, 16'h9998);
    step("sat", 0, 0, 1, 0, 0); chk("sat_abs", disp_num, 16'h9999);
    step("sat2", 0, 0, 1, 0, 0); chk("sat_hold", disp_num, 16'h9999);
    step("restart2", 1, 0, 0, 0, 0);
    step("prio", 0, 0, 1, 1, 1);
    chk("prio_num", disp_num, 16'h0003); chk("prio_combo", {9'h0, combo}, 16'h0001);
    step("start_over", 1, 1, 0, 0, 0); chk("start_wins", disp_num, 16'h0000);
    repeat (9) step("to42", 0, 0, 1, 0, 0);
    step("to42m", 0, 0, 0, 0, 1);
    repeat (5) step("to42", 0, 0, 1, 0, 0);
    chk("score42", disp_num, 16'h0042);
    step("over", 0, 1, 0, 0, 0); chk("over_pt", {12'h0, disp_point}, 16'h0008);
    for (int i = 0; i < 14; i++) step("blink", 0, 0, 1'($urandom), 1'($urandom), 1'($urandom));
    do_reset(1);
    for (int i = 0; i < 600; i++)
      step("rnd_all", $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           1'($urandom), 1'($urandom), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
